// File: rtl/lc3_mem_ctrl_if.sv
// LC3 memory controller bus: instruction fetch, data access and preload.
// master = core/requester side, slave = controller side.
interface lc3_mem_ctrl_if;
   logic        instrmem_rd;
   logic [15:0] pc;
   logic [15:0] Instr_dout;
   logic        complete_instr;
   logic        data_req;
   logic        Data_rd;
   logic [15:0] Data_addr;
   logic [15:0] Data_din;
   logic [15:0] Data_dout;
   logic        complete_data;
   logic        load_en;
   logic [15:0] load_addr;
   logic [15:0] load_data;
   logic        busy;

   modport master (
      output instrmem_rd, pc,
      output data_req, Data_rd, Data_addr, Data_din,
      output load_en, load_addr, load_data,
      input  Instr_dout, complete_instr,
      input  Data_dout, complete_data, busy
   );

   modport slave (
      input  instrmem_rd, pc,
      input  data_req, Data_rd, Data_addr, Data_din,
      input  load_en, load_addr, load_data,
      output Instr_dout, complete_instr,
      output Data_dout, complete_data, busy
   );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// Wait-state controller serving LC3 fetch and data ports from one word array.
// Ports: clock, reset (sync, active-high), bus (lc3_mem_ctrl_if.slave).
module lc3_mem_ctrl #(
   parameter int ADDR_W = 12,
   parameter int WAIT   = 2
) (
   input logic          clock,
   input logic          reset,
   lc3_mem_ctrl_if.slave bus
);
   localparam logic [3:0] WAIT_C = 4'(WAIT);

   typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

   state_t state, state_nx;
   logic [3:0] cnt, cnt_nx;

   logic [15:0] mem [0:(2**ADDR_W)-1];

   logic [ADDR_W-1:0] lat_addr;
   logic              lat_rd;
   logic [15:0]       lat_din;

   logic              take_d, take_i;
   logic              fin_i, fin_d;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [15:0]       mem_wdata;

   // Upper address bits are dropped on purpose (wrap).
   logic addr_unused;
   assign addr_unused = ^{bus.pc, bus.Data_addr, bus.load_addr};

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         lat_addr <= '0;
         lat_rd   <= 1'b0;
         lat_din  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (take_d) begin
            lat_addr <= bus.Data_addr[ADDR_W-1:0];
            lat_rd   <= bus.Data_rd;
            lat_din  <= bus.Data_din;
         end else if (take_i) begin
            lat_addr <= bus.pc[ADDR_W-1:0];
         end
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      take_d    = 1'b0;
      take_i    = 1'b0;
      fin_i     = 1'b0;
      fin_d     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = bus.load_addr[ADDR_W-1:0];
      mem_wdata = bus.load_data;
      case (state)
         IDLE: begin
            // Preload, then data, then fetch: data stalls drain first.
            if (bus.load_en) begin
               mem_we = 1'b1;
            end else if (bus.data_req) begin
               take_d   = 1'b1;
               cnt_nx   = WAIT_C;
               state_nx = D_WAIT;
            end else if (bus.instrmem_rd) begin
               take_i   = 1'b1;
               cnt_nx   = WAIT_C;
               state_nx = I_WAIT;
            end
         end
         I_WAIT: begin
            if (cnt != 4'd0) begin
               cnt_nx = cnt - 4'd1;
            end else begin
               fin_i    = 1'b1;
               state_nx = IDLE;
            end
         end
         D_WAIT: begin
            if (cnt != 4'd0) begin
               cnt_nx = cnt - 4'd1;
            end else begin
               fin_d     = 1'b1;
               mem_we    = !lat_rd;
               mem_waddr = lat_addr;
               mem_wdata = lat_din;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Reset on the same edge aborts a pending write.
   always_ff @(posedge clock) begin
      if (mem_we && !reset)
         mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bus.Instr_dout     <= '0;
         bus.Data_dout      <= '0;
         bus.complete_instr <= 1'b0;
         bus.complete_data  <= 1'b0;
      end else begin
         bus.complete_instr <= fin_i;
         bus.complete_data  <= fin_d;
         if (fin_i)
            bus.Instr_dout <= mem[lat_addr];
         if (fin_d && lat_rd)
            bus.Data_dout <= mem[lat_addr];
      end
   end

   assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: three instances with WAIT = 0, 1, 2.
// Stimulus pushes expected completions; a negedge monitor pops and checks.
module tb_lc3_mem_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          id;
      logic        is_data;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t q[$];

   logic        rst  [3];
   logic        irq  [3];
   logic [15:0] pcv  [3];
   logic        dq   [3];
   logic        drd  [3];
   logic [15:0] dad  [3];
   logic [15:0] ddin [3];
   logic        ld   [3];
   logic [15:0] lad  [3];
   logic [15:0] ldat [3];

   logic [15:0] ido [3];
   logic [15:0] ddo [3];
   logic        ci  [3];
   logic        cd  [3];
   logic        bsy [3];

   logic [15:0] ddo_m [3];

   lc3_mem_ctrl_if bus0 ();
   lc3_mem_ctrl_if bus1 ();
   lc3_mem_ctrl_if bus2 ();

   assign bus0.instrmem_rd = irq[0];
   assign bus0.pc          = pcv[0];
   assign bus0.data_req    = dq[0];
   assign bus0.Data_rd     = drd[0];
   assign bus0.Data_addr   = dad[0];
   assign bus0.Data_din    = ddin[0];
   assign bus0.load_en     = ld[0];
   assign bus0.load_addr   = lad[0];
   assign bus0.load_data   = ldat[0];
   assign ido[0] = bus0.Instr_dout;
   assign ddo[0] = bus0.Data_dout;
   assign ci[0]  = bus0.complete_instr;
   assign cd[0]  = bus0.complete_data;
   assign bsy[0] = bus0.busy;

   assign bus1.instrmem_rd = irq[1];
   assign bus1.pc          = pcv[1];
   assign bus1.data_req    = dq[1];
   assign bus1.Data_rd     = drd[1];
   assign bus1.Data_addr   = dad[1];
   assign bus1.Data_din    = ddin[1];
   assign bus1.load_en     = ld[1];
   assign bus1.load_addr   = lad[1];
   assign bus1.load_data   = ldat[1];
   assign ido[1] = bus1.Instr_dout;
   assign ddo[1] = bus1.Data_dout;
   assign ci[1]  = bus1.complete_instr;
   assign cd[1]  = bus1.complete_data;
   assign bsy[1] = bus1.busy;

   assign bus2.instrmem_rd = irq[2];
   assign bus2.pc          = pcv[2];
   assign bus2.data_req    = dq[2];
   assign bus2.Data_rd     = drd[2];
   assign bus2.Data_addr   = dad[2];
   assign bus2.Data_din    = ddin[2];
   assign bus2.load_en     = ld[2];
   assign bus2.load_addr   = lad[2];
   assign bus2.load_data   = ldat[2];
   assign ido[2] = bus2.Instr_dout;
   assign ddo[2] = bus2.Data_dout;
   assign ci[2]  = bus2.complete_instr;
   assign cd[2]  = bus2.complete_data;
   assign bsy[2] = bus2.busy;

   lc3_mem_ctrl #(.ADDR_W(12), .WAIT(0)) dut0 (
      .clock(clk), .reset(rst[0]), .bus(bus0.slave));
   lc3_mem_ctrl #(.ADDR_W(12), .WAIT(1)) dut1 (
      .clock(clk), .reset(rst[1]), .bus(bus1.slave));
   lc3_mem_ctrl #(.ADDR_W(12), .WAIT(2)) dut2 (
      .clock(clk), .reset(rst[2]), .bus(bus2.slave));

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   function automatic bit has(input int id);
      foreach (q[i]) if (q[i].id == id) return 1'b1;
      return 1'b0;
   endfunction

   task automatic mon(input int id, input logic c_i, input logic c_d,
                      input logic [15:0] i_o, input logic [15:0] d_o,
                      input logic b);
      int idx;
      exp_t e;
      logic [15:0] got;
      if (c_i && c_d) begin
         tests++;
         fails++;
         $display("FAIL overlap dut%0d cyc %0d: both pulses high, required one",
                  id, cyc);
      end
      if (c_i || c_d) begin
         idx = -1;
         foreach (q[i]) if (idx < 0 && q[i].id == id) idx = i;
         tests++;
         if (idx < 0) begin
            fails++;
            $display("FAIL unexpected dut%0d cyc %0d: ci=%0b cd=%0b, required none",
                     id, cyc, c_i, c_d);
         end else begin
            e = q[idx];
            q.delete(idx);
            got = c_d ? d_o : i_o;
            if (c_d !== e.is_data || cyc != e.cyc || got !== e.data || b !== 1'b0) begin
               fails++;
               $display("FAIL complete dut%0d: data=%0b cyc=%0d val=%h busy=%0b required data=%0b cyc=%0d val=%h busy=0",
                        id, c_d, cyc, got, b, e.is_data, e.cyc, e.data);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++)
         mon(i, ci[i], cd[i], ido[i], ddo[i], bsy[i]);
   end

   task automatic push(input int id, input logic is_d,
                       input logic [15:0] v, input int c);
      exp_t e;
      e.id = id;
      e.is_data = is_d;
      e.data = v;
      e.cyc = c;
      q.push_back(e);
   endtask

   task automatic drain(input int id);
      int n = 0;
      while (has(id) && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (has(id)) begin
         tests++;
         fails++;
         $display("FAIL timeout dut%0d: completion missing, required pulse", id);
         for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].id == id) q.delete(i);
      end
   endtask

   task automatic load(input int id, input logic [15:0] a,
                       input logic [15:0] d);
      @(negedge clk);
      ld[id] = 1'b1;
      lad[id] = a;
      ldat[id] = d;
      @(negedge clk);
      ld[id] = 1'b0;
   endtask

   // One request per call; WAIT of instance id equals id.
   task automatic access(input int id, input logic is_d, input logic rd,
                         input logic [15:0] a, input logic [15:0] din,
                         input logic [15:0] v);
      logic [15:0] ev;
      @(negedge clk);
      if (is_d) begin
         dq[id] = 1'b1;
         drd[id] = rd;
         dad[id] = a;
         ddin[id] = din;
         if (rd) ddo_m[id] = v;
         ev = ddo_m[id];
      end else begin
         irq[id] = 1'b1;
         pcv[id] = a;
         ev = v;
      end
      push(id, is_d, ev, cyc + id + 2);
      for (int k = 0; k <= id; k++) begin
         @(negedge clk);
         if (k == 0) begin
            dq[id] = 1'b0;
            irq[id] = 1'b0;
         end
         chk($sformatf("busy dut%0d k%0d", id, k), 32'(bsy[id]), 32'd1);
      end
      @(negedge clk);
      #1;
      drain(id);
   endtask

   initial begin
      int e0;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1;
         irq[i] = 1'b0;
         pcv[i] = '0;
         dq[i] = 1'b0;
         drd[i] = 1'b0;
         dad[i] = '0;
         ddin[i] = '0;
         ld[i] = 1'b0;
         lad[i] = '0;
         ldat[i] = '0;
         ddo_m[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset dout dut%0d", i), {ido[i], ddo[i]}, 32'd0);
         chk($sformatf("reset flags dut%0d", i),
             32'({ci[i], cd[i], bsy[i]}), 32'd0);
         rst[i] = 1'b0;
      end

      // Preload and fetch, WAIT=2
      load(2, 16'h0010, 16'h1234);
      access(2, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h1234);

      // Write then read
      access(2, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0);
      access(2, 1'b1, 1'b1, 16'h0020, 16'h0, 16'hBEEF);
      chk("instr hold", 32'(ido[2]), 32'h1234);

      // Address wrap
      access(2, 1'b0, 1'b0, 16'h1010, 16'h0, 16'h1234);

      // Reset in the 2nd D_WAIT cycle of a write
      load(2, 16'h0030, 16'h5555);
      @(negedge clk);
      dq[2] = 1'b1;
      drd[2] = 1'b0;
      dad[2] = 16'h0030;
      ddin[2] = 16'hAAAA;
      @(negedge clk);
      dq[2] = 1'b0;
      @(negedge clk);
      rst[2] = 1'b1;
      @(negedge clk);
      rst[2] = 1'b0;
      ddo_m[2] = 16'h0;
      chk("abort dout", {ido[2], ddo[2]}, 32'd0);
      chk("abort flags", 32'({ci[2], cd[2], bsy[2]}), 32'd0);
      repeat (5) @(negedge clk);
      access(2, 1'b1, 1'b1, 16'h0030, 16'h0, 16'h5555);

      // Preload while busy is ignored
      load(2, 16'h0040, 16'h7777);
      @(negedge clk);
      irq[2] = 1'b1;
      pcv[2] = 16'h0010;
      push(2, 1'b0, 16'h1234, cyc + 4);
      @(negedge clk);
      irq[2] = 1'b0;
      chk("busy at load", 32'(bsy[2]), 32'd1);
      ld[2] = 1'b1;
      lad[2] = 16'h0040;
      ldat[2] = 16'h9999;
      @(negedge clk);
      ld[2] = 1'b0;
      drain(2);
      access(2, 1'b1, 1'b1, 16'h0040, 16'h0, 16'h7777);

      // Simultaneous data read and fetch, WAIT=1
      load(1, 16'h0010, 16'h1234);
      load(1, 16'h0020, 16'hBEEF);
      @(negedge clk);
      dq[1] = 1'b1;
      drd[1] = 1'b1;
      dad[1] = 16'h0020;
      irq[1] = 1'b1;
      pcv[1] = 16'h0010;
      e0 = cyc + 1;
      push(1, 1'b1, 16'hBEEF, e0 + 2);
      push(1, 1'b0, 16'h1234, e0 + 5);
      @(negedge clk);
      dq[1] = 1'b0;
      repeat (3) @(negedge clk);
      irq[1] = 1'b0;
      drain(1);

      // Held fetch, WAIT=0: one completion every 2 cycles
      load(0, 16'h0010, 16'h1234);
      @(negedge clk);
      irq[0] = 1'b1;
      pcv[0] = 16'h0010;
      e0 = cyc + 1;
      push(0, 1'b0, 16'h1234, e0 + 1);
      push(0, 1'b0, 16'h1234, e0 + 3);
      push(0, 1'b0, 16'h1234, e0 + 5);
      repeat (5) @(negedge clk);
      irq[0] = 1'b0;
      drain(0);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Wait-state memory controller serving the LC3 core's instruction and data ports from one single-port word array. Sits directly downstream of the core's `pc`/`instrmem_rd` and `Data_addr`/`Data_rd`/`Data_din` outputs. Produces `Instr_dout`, `Data_dout`, `complete_instr` and `complete_data` after a programmable latency. Gives the pipeline controller a realistic, stalling memory instead of a zero-latency model.

## Interface
- `ADDR_W`, 12: array depth is 2^ADDR_W 16-bit words; address bits above ADDR_W-1 are ignored (wrap).
- `WAIT`, 2: extra wait cycles per access; legal range 0..15.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `instrmem_rd`  in  1  instruction fetch request; hold until `complete_instr`.
- `pc`  in  16  fetch address.
- `Instr_dout`  out  16  fetched word; holds its value until the next fetch completes.
- `complete_instr`  out  1  one-cycle pulse: fetch done, `Instr_dout` valid.
- `data_req`  in  1  data access request; hold until `complete_data`.
- `Data_rd`  in  1  1 = read, 0 = write; sampled with `data_req`.
- `Data_addr`  in  16  data address.
- `Data_din`  in  16  write data.
- `Data_dout`  out  16  read word; holds until the next data read completes.
- `complete_data`  out  1  one-cycle pulse: data access done.
- `load_en`  in  1  bench preload write strobe, honoured only in IDLE.
- `load_addr`  in  16  preload address.
- `load_data`  in  16  preload data.
- `busy`  out  1  high in I_WAIT and D_WAIT.

## Operation
- States: IDLE, I_WAIT, D_WAIT. A 4-bit counter `cnt` tracks wait cycles.
- Registered outputs: `Instr_dout`, `Data_dout`, `complete_instr`, `complete_data`. `busy` is decoded from state.
- IDLE selects one action per edge, in this priority order:
  - `load_en`: write `load_data` to `mem[load_addr[ADDR_W-1:0]]`, stay in IDLE.
  - `data_req`: latch address, `Data_rd` and `Data_din`; set `cnt`=WAIT; go to D_WAIT.
  - `instrmem_rd`: latch `pc`; set `cnt`=WAIT; go to I_WAIT.
- Data has priority over fetch, so memory stalls drain before new fetches.
- In I_WAIT or D_WAIT, on each edge:
  - If `cnt`≠0: `cnt` decrements.
  - If `cnt`=0, perform the access:
    - I_WAIT: `Instr_dout`←mem, pulse `complete_instr`.
    - D_WAIT read: `Data_dout`←mem, pulse `complete_data`.
    - D_WAIT write: mem←latched din, `Data_dout` unchanged, pulse `complete_data`.
    - Return to IDLE.
- Request inputs are ignored outside IDLE, as are `load_en`, address and data inputs. Only the latched copies are used.
- A request still high in IDLE is a new request, including the cycle in which `complete_*` is high. Requesters must drop the request on seeing `complete_*` unless a back-to-back access is intended.
- Address wrap: only `[ADDR_W-1:0]` indexes the array; no error is flagged.

## Timing
- Reset, sampled at an edge, sets:
  - state IDLE, `cnt`=0, `busy`=0;
  - `complete_instr`=0, `complete_data`=0;
  - `Instr_dout`=0x0000, `Data_dout`=0x0000.
- Memory contents are not cleared by reset.
- Latency: a request sampled in IDLE at edge E0 completes at edge E0+WAIT+1.
  - `complete_*` is high for exactly the cycle after that edge.
  - WAIT=0 gives 1 cycle; WAIT=2 gives 3 cycles.
- Throughput: a continuously held `instrmem_rd` is re-accepted at edge E0+WAIT+2, giving one fetch every WAIT+2 cycles.
- `data_req` and `instrmem_rd` both high in IDLE at edge E0:
  - `complete_data` follows edge E0+WAIT+1.
  - The fetch is accepted at edge E0+WAIT+2.
  - `complete_instr` follows edge E0+2·WAIT+3.
- Reset mid-access aborts the access: no write is performed, no `complete_*` pulse, outputs take reset values.
- `complete_instr` and `complete_data` are never high in the same cycle.
- `busy` is low in the completion cycle.

## Test plan
- Preload and fetch. Preload `mem[0x010]`=0x1234; WAIT=2; hold `instrmem_rd`=1 with `pc`=0x0010. Required: `complete_instr` pulses 3 cycles after acceptance, `Instr_dout`=0x1234, `busy` high for 3 cycles.
- Write then read. Data write `Data_addr`=0x0020, `Data_din`=0xBEEF. Required: `complete_data` pulses and `Data_dout` stays 0x0000. Then read 0x0020. Required: `Data_dout`=0xBEEF and `Instr_dout` unchanged.
- Simultaneous requests, WAIT=1. Assert `data_req` (read 0x0020) and `instrmem_rd` (`pc`=0x0010) together. Required: `complete_data` at +2 and `complete_instr` at +5 cycles. No overlap between the two pulses.
- Reset mid-write. Issue a write of 0xAAAA to 0x0030, which holds 0x5555, and assert `reset` in the 2nd D_WAIT cycle. Required: no `complete_data`, all outputs 0, and a later read of 0x0030 returns 0x5555.
- Address wrap, ADDR_W=12. Fetch `pc`=0x1010. Required: returns 0x1234, the contents of `mem[0x010]`.
- Ignored preload. Pulse `load_en` to 0x0040 while `busy`=1. Required: a later read of 0x0040 shows its previous value. WAIT=0 back-to-back fetches complete every 2 cycles.
